// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and defaults for the serial pattern blocks
package serial_pkg;

  // Controller states; 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } ser_state_t;

  // Default word width and gap length shared with the serial detectors
  localparam int SER_W   = 8;
  localparam int SER_GAP = 2;

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - parallel-in serial-out shift register, MSB first
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data,
  output logic         sout
);

  logic [W-1:0] shreg;

  // Load has priority over shift; shifting fills with zeros so the register drains to all-zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= data;
    end else if (shift) begin
      shreg <= {shreg[W-2:0], 1'b0};
    end
  end

  assign sout = shreg[W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - word-to-serial pattern transmitter with forced-zero gap
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int W   = SER_W,
  parameter int GAP = SER_GAP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         x,
  output logic         x_en,
  output logic         done,
  output logic [7:0]   tx_count
);

  // The local parameter GAP shadows the state name, so the state is always package-qualified
  localparam int BW = (W > 2) ? $clog2(W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

  ser_state_t    state;
  logic [BW-1:0] bitcnt;
  logic [3:0]    gapcnt;
  logic          load;
  logic          shift;
  logic          sout;

  // Word capture happens only on the accepting edge; shifting only while in SHIFT
  assign load  = (state == IDLE) && in_valid;
  assign shift = (state == SHIFT);

  piso_shreg #(
    .W(W)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .data  (in_data),
    .sout  (sout)
  );

  // Data bit is gated by the registered enable so x stays zero outside SHIFT
  assign x = sout & x_en;

  // Controller: state, counters and registered handshake/status outputs move together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bitcnt   <= '0;
      gapcnt   <= '0;
      tx_count <= '0;
      in_ready <= 1'b1;
      x_en     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            bitcnt   <= BIT_LAST;
            state    <= SHIFT;
            in_ready <= 1'b0;
            x_en     <= 1'b1;
          end
        end
        SHIFT: begin
          bitcnt <= bitcnt - 1'b1;
          if (bitcnt == '0) begin
            gapcnt <= GAP_LAST;
            state  <= serial_pkg::GAP;
            x_en   <= 1'b0;
            // A one-bit gap is already on its last cycle when entered
            done   <= (GAP == 1);
          end
        end
        serial_pkg::GAP: begin
          gapcnt <= gapcnt - 1'b1;
          // Raise done for the cycle in which gapcnt will read zero
          done   <= (gapcnt == 4'd1);
          if (gapcnt == 4'd0) begin
            tx_count <= tx_count + 8'd1;
            state    <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          x_en     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - directed self-checking bench for serial_pattern_tx
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       x;
  logic       x_en;
  logic       done;
  logic [7:0] tx_count;

  int pass_cnt = 0;
  int total = 0;

  serial_pattern_tx #(
    .W   (8),
    .GAP (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .x        (x),
    .x_en     (x_en),
    .done     (done),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hB6;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({in_ready, x, x_en, done, tx_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0})
        $display("FAIL reset_outputs cyc%0d: got rdy=%b x=%b en=%b done=%b cnt=%0d want 1 0 0 0 0",
                 c, in_ready, x, x_en, done, tx_count);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    total++;
    if ({in_ready, x_en} !== 2'b10)
      $display("FAIL reset_no_accept: got rdy=%b en=%b want rdy=1 en=0", in_ready, x_en);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hB6;
    in_valid = 1'b1;
    in_data = w;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({x, x_en, done} !== {w[7-k], 1'b1, 1'b0})
        $display("FAIL single_bit T%0d: got x=%b en=%b done=%b want x=%b en=1 done=0",
                 k + 1, x, x_en, done, w[7-k]);
      else pass_cnt++;
      tick();
    end
    total++;
    if ({x, x_en, done, in_ready} !== 4'b0000)
      $display("FAIL single_gap T9: got x=%b en=%b done=%b rdy=%b want 0 0 0 0", x, x_en, done, in_ready);
    else pass_cnt++;
    tick();
    total++;
    if ({x, x_en, done, in_ready} !== 4'b0010)
      $display("FAIL single_done T10: got x=%b en=%b done=%b rdy=%b want 0 0 1 0", x, x_en, done, in_ready);
    else pass_cnt++;
    tick();
    total++;
    if ({in_ready, done, tx_count} !== {1'b1, 1'b0, 8'd1})
      $display("FAIL single_idle T11: got rdy=%b done=%b cnt=%0d want 1 0 1", in_ready, done, tx_count);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1;
    logic [7:0] w2;
    logic       ex;
    w1 = 8'hFF;
    w2 = 8'h01;
    in_valid = 1'b1;
    in_data = w1;
    tick();
    in_data = w2;
    for (int c = 1; c <= 22; c++) begin
      if (c >= 1 && c <= 8) ex = w1[8-c];
      else if (c >= 12 && c <= 19) ex = w2[19-c];
      else ex = 1'b0;
      total++;
      if ({x, done, in_ready} !== {ex, (c == 10 || c == 21), (c == 11 || c == 22)})
        $display("FAIL b2b T%0d: got x=%b done=%b rdy=%b want x=%b done=%b rdy=%b",
                 c, x, done, in_ready, ex, (c == 10 || c == 21), (c == 11 || c == 22));
      else pass_cnt++;
      if (c == 12) in_valid = 1'b0;
      if (c < 22) tick();
    end
    total++;
    if (tx_count !== 8'd3)
      $display("FAIL b2b_count: got %0d want 3", tx_count);
    else pass_cnt++;
  endtask

  task automatic test_ignore_busy();
    logic [7:0] w;
    int         dcnt;
    w = 8'hB6;
    dcnt = 0;
    in_valid = 1'b1;
    in_data = w;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin
        in_data = 8'h00;
        in_valid = 1'b1;
      end
      if (c == 10) in_valid = 1'b0;
      if (c <= 8) begin
        total++;
        if ({x, x_en} !== {w[8-c], 1'b1})
          $display("FAIL busy_bit T%0d: got x=%b en=%b want x=%b en=1", c, x, x_en, w[8-c]);
        else pass_cnt++;
      end
      if (done === 1'b1) dcnt++;
      if (c < 12) tick();
    end
    total++;
    if (dcnt !== 1 || tx_count !== 8'd4 || in_ready !== 1'b1)
      $display("FAIL busy_count: got done=%0d cnt=%0d rdy=%b want done=1 cnt=4 rdy=1", dcnt, tx_count, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    int         dcnt;
    w = 8'hB6;
    dcnt = 0;
    in_valid = 1'b1;
    in_data = w;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({x, x_en, done, in_ready, tx_count} !== {4'b0001, 8'd0})
      $display("FAIL midrst_async: got x=%b en=%b done=%b rdy=%b cnt=%0d want 0 0 0 1 0",
               x, x_en, done, in_ready, tx_count);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    total++;
    if (dcnt !== 0 || tx_count !== 8'd0)
      $display("FAIL midrst_nodone: got done=%0d cnt=%0d want 0 0", dcnt, tx_count);
    else pass_cnt++;
    w = 8'h9C;
    in_valid = 1'b1;
    in_data = w;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 8) begin
        total++;
        if ({x, x_en} !== {w[8-c], 1'b1})
          $display("FAIL midrst_bit T%0d: got x=%b en=%b want x=%b en=1", c, x, x_en, w[8-c]);
        else pass_cnt++;
      end
      if (c == 10) begin
        total++;
        if (done !== 1'b1)
          $display("FAIL midrst_done T10: got %b want 1", done);
        else pass_cnt++;
      end
      if (c < 11) tick();
    end
    total++;
    if ({in_ready, tx_count} !== {1'b1, 8'd1})
      $display("FAIL midrst_after: got rdy=%b cnt=%0d want 1 1", in_ready, tx_count);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int dcnt;
    int cyc;
    bit check_next;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    dcnt = 0;
    cyc = 0;
    check_next = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    while (dcnt < 256 && cyc < 3000) begin
      tick();
      cyc++;
      if (check_next) begin
        total++;
        if (tx_count !== 8'd255)
          $display("FAIL wrap_255: got %0d want 255", tx_count);
        else pass_cnt++;
      end
      check_next = 1'b0;
      if (done === 1'b1) begin
        dcnt++;
        if (dcnt == 255) check_next = 1'b1;
        if (dcnt == 256) in_valid = 1'b0;
      end
    end
    total++;
    if (dcnt !== 256)
      $display("FAIL wrap_timeout: got %0d done pulses want 256 within budget", dcnt);
    else pass_cnt++;
    tick();
    total++;
    if ({in_ready, tx_count} !== {1'b1, 8'd0})
      $display("FAIL wrap_zero: got rdy=%b cnt=%0d want 1 0", in_ready, tx_count);
    else pass_cnt++;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    total++;
    if (dcnt !== 256 || tx_count !== 8'd0)
      $display("FAIL wrap_final: got done=%0d cnt=%0d want 256 0", dcnt, tx_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Word-to-serial pattern transmitter: accepts a parallel W-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a single-bit serial line. Each word is followed by a fixed run of forced-zero gap bits, so a downstream serial sequence detector sees a clean word boundary. The block sits upstream of the serial detectors in the design and is the stimulus source for them. Control is a 3-state Moore FSM; every output is a function of registered state only.

## Interface
- W, 8: data word width; legal range 2..32.
- GAP, 2: number of forced-zero bit times after each word; legal range 1..15.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer presents a word.
- in_ready  out  1  block can accept a word; high only in IDLE.
- in_data  in  W  word to transmit; sampled only at the accepting edge.
- x  out  1  serial data bit.
- x_en  out  1  high while x carries a data bit (SHIFT state only).
- done  out  1  one-cycle pulse on the last gap cycle of each word.
- tx_count  out  8  number of completed words, wrapping modulo 256.

## Operation
- FSM states and encoding: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10; 2'b11 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - Outputs: in_ready=1, x=0, x_en=0, done=0.
  - If in_valid=1 at an edge: shreg<=in_data, bitcnt<=W-1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Outputs: x=shreg[W-1], x_en=1, in_ready=0.
  - Each edge: shreg<=shreg<<1 with zero fill, bitcnt<=bitcnt-1.
  - When bitcnt==0: gapcnt<=GAP-1, go to GAP.
- GAP:
  - Outputs: x=0, x_en=0, in_ready=0.
  - done=1 while gapcnt==0.
  - Each edge: gapcnt<=gapcnt-1.
  - When gapcnt==0: tx_count<=tx_count+1 (8-bit wrap, 255->0), go to IDLE.
- in_valid and in_data are ignored outside IDLE; changing in_data mid-word has no effect on x.
- Widths:
  - bitcnt is $clog2(W) bits; it holds values W-1..0 and never underflows in use.
  - gapcnt is 4 bits.
- Reset (at any time, including mid-word):
  - State is forced to IDLE; shreg, bitcnt, gapcnt and tx_count are cleared to 0.
  - The word in flight is discarded with no done pulse.
  - Reset values: in_ready=1, x=0, x_en=0, done=0, tx_count=0.

## Timing
- Accept edge T0 (in_valid & in_ready). Data bit k (MSB first, k=0..W-1) is on x during cycle T0+1+k.
- GAP occupies cycles T0+W+1 .. T0+W+GAP; done is high in cycle T0+W+GAP.
- IDLE (in_ready=1) resumes at T0+W+GAP+1; tx_count shows the increment from that cycle.
- With in_valid held high, back-to-back words repeat every W+GAP+1 cycles.
- Between words x=0 for at least GAP+1 consecutive cycles.
- No combinational path from any input to any output.

## Structure
- Shared package serial_pkg holds:
  - the state typedef and its encodings (IDLE, SHIFT, GAP);
  - default constants SER_W=8 and SER_GAP=2.
  - The serial detectors use the same package.
- One sub-module is natural: piso_shreg (parameter W; load/shift enables; serial out = MSB).
- The FSM, bit/gap counters and tx_count live in the top module.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1.
  - Required: in_ready=1, x=0, x_en=0, done=0, tx_count=0 throughout.
  - Required: no word is accepted while rst=0.
- Single word, W=8, GAP=2, in_data=8'hB6 accepted at T0:
  - x over T1..T8 = 1,0,1,1,0,1,1,0 with x_en=1.
  - T9 and T10: x=0, x_en=0; done=1 in T10 only.
  - T11: in_ready=1, tx_count=1.
- Back-to-back: in_valid held, words 8'hFF then 8'h01.
  - Second accept at T11; x=1 for T1..T8.
  - x over T12..T19 = 0,0,0,0,0,0,0,1; done in T10 and T21.
- Ignore while busy: change in_data to 8'h00 and pulse in_valid during T3..T9 of an 8'hB6 word.
  - Transmitted bits are unchanged; exactly one word is counted.
- Reset mid-word: assert rst in T4 of 8'hB6.
  - x, x_en, tx_count go to 0 immediately; no done pulse.
  - After release the next accepted word transmits correctly from its MSB.
- Counter wrap: send 256 words of 8'h5A.
  - tx_count reads 255 after 255 words and 0 after word 256.
  - done pulses exactly 256 times.
